updown_counter_mod: RTL and testbench
=====================================

Name: updown_counter_mod

Overview:
- Parametrised successor to the team's 4-bit up/down counter.
- Generalises width and modulus.
- Adds count enable, synchronous parallel load, and a selectable wrap or saturate mode.
- Adds a terminal-count flag, a registered carry/borrow pulse, and sticky overflow/underflow flags with software clear.
- Used as a general event/position counter and as a programmable divider tick source in datapath and timer blocks.

Parameters:
- WIDTH, default 4: counter width in bits; must be ≥ 1.
- MODULUS, default 16: count range is 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2**WIDTH.
- RESET_VAL, default 0: value loaded on reset; must be < MODULUS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; 1 = step this cycle.
- ctrl  in  1  direction; 1 = up, 0 = down (same encoding as the existing counter).
- sat_mode  in  1  0 = wrap at boundary, 1 = saturate at boundary; sampled every cycle.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value to load.
- clr_flags  in  1  clears ovf and unf.
- out  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational: (ctrl=1 and out=MODULUS-1) or (ctrl=0 and out=0).
- carry  out  1  registered one-cycle pulse on a boundary event.
- ovf  out  1  sticky: an up-step was attempted at MODULUS-1.
- unf  out  1  sticky: a down-step was attempted at 0.

Behaviour:
- Only clk and rst are decided; one clock domain. All state updates on the rising edge of clk.
- Let MAX = MODULUS-1.
- Reset (rst=1 at the edge): out=RESET_VAL, carry=0, ovf=0, unf=0. Reset overrides all other inputs. No counting happens in a reset cycle. Reset mid-count discards the count immediately.
- Priority when not in reset: load > en-step > hold.
- Load:
  - out <= min(load_val, MAX); out-of-range values clamp to MAX.
  - carry=0 that cycle. Flags are unaffected except by clr_flags.
  - Load with en=1 performs the load only.
- Step (en=1, load=0), up direction:
  - out < MAX: out+1.
  - out = MAX and sat_mode=0: out <= 0, carry pulses, ovf set.
  - out = MAX and sat_mode=1: out holds at MAX, carry pulses, ovf set.
- Step, down direction:
  - out > 0: out-1.
  - out = 0 and sat_mode=0: out <= MAX, carry pulses, unf set.
  - out = 0 and sat_mode=1: out holds at 0, carry pulses, unf set.
- carry:
  - High for exactly the cycle after the boundary-step edge; 0 otherwise.
  - Back-to-back boundary steps in saturate mode give a continuous carry.
- en=0: out, ovf and unf hold; carry=0.
- clr_flags:
  - Clears ovf and unf at the edge.
  - If a boundary event occurs in the same cycle, set wins (flag reads 1 afterwards).
- Arithmetic:
  - Internal compare/increment is WIDTH bits wide.
  - When MODULUS = 2**WIDTH, natural WIDTH-bit wrap must give the same result as the explicit MAX compare.
  - No internal value may ever exceed MAX.
- Direction or mode may change on any cycle; the new value applies to that cycle's step.
- tc follows out and ctrl combinationally; it is valid during reset with out=RESET_VAL.

Decomposition:
- Shared package counter_pkg:
  - localparams DIR_DOWN=0, DIR_UP=1, MODE_WRAP=0, MODE_SAT=1.
  - Function clamp_to_max(value, max) used by load and by future counter variants.
- Single module; no sub-module is warranted. Next-state logic is one combinational block feeding one registered always block for out, carry, ovf and unf.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0 unless noted):
- Reset then en=1, ctrl=1, sat_mode=0 for 12 cycles -> out 1..9, 0, 1, 2; carry high only the cycle after the 9->0 edge; ovf=1 afterwards; tc=1 while out=9.
- From out=0: ctrl=0, sat_mode=1, en=1 for 3 cycles -> out stays 0; carry high on all 3 following cycles; unf=1; ovf unchanged.
- load=1, load_val=13, en=1 -> out=9 next cycle, carry=0. Then load_val=4 -> out=4.
- Count to 7, then assert rst for 1 cycle with en=1, ctrl=1 -> out=0, flags 0, carry=0. Counting resumes 1, 2 on the following cycles.
- With ovf=1, assert clr_flags in the same cycle as a 9->0 wrap -> ovf stays 1. clr_flags alone on the next cycle -> ovf=0.
- MODULUS=16, RESET_VAL=15: after reset tc=1 with ctrl=1; one up-step -> out=0, carry pulse. One down-step -> out=15, unf=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: direction/mode encodings
// and the load-value clamp helper.
package counter_pkg;

   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Counter variants up to this width share the clamp helper.
   localparam int unsigned CLAMP_W = 32;

   function automatic logic [CLAMP_W-1:0] clamp_to_max(
      input logic [CLAMP_W-1:0] value,
      input logic [CLAMP_W-1:0] max
   );
      if (value > max) begin
         return max;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with enable, parallel load, wrap/saturate
// mode, terminal count, registered carry/borrow pulse and sticky ovf/unf flags.
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MODULUS   = 16,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ctrl,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             carry,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

   logic [WIDTH-1:0] r_out;
   logic             r_carry;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_next_out;
   logic             w_next_carry;
   logic             w_set_ovf;
   logic             w_set_unf;
   logic             w_next_ovf;
   logic             w_next_unf;

   assign w_load_clamped = WIDTH'(clamp_to_max(CLAMP_W'(load_val), CLAMP_W'(MAX)));

   // Next-state selection: load beats step, step beats hold; boundaries via explicit MAX/0 compare.
   always_comb begin
      w_next_out   = r_out;
      w_next_carry = 1'b0;
      w_set_ovf    = 1'b0;
      w_set_unf    = 1'b0;
      if (load) begin
         w_next_out = w_load_clamped;
      end else if (en) begin
         if (ctrl == DIR_UP) begin
            if (r_out == MAX) begin
               w_next_carry = 1'b1;
               w_set_ovf    = 1'b1;
               if (sat_mode == MODE_SAT) begin
                  w_next_out = MAX;
               end else begin
                  w_next_out = ZERO;
               end
            end else begin
               w_next_out = r_out + ONE_VAL;
            end
         end else begin
            if (r_out == ZERO) begin
               w_next_carry = 1'b1;
               w_set_unf    = 1'b1;
               if (sat_mode == MODE_SAT) begin
                  w_next_out = ZERO;
               end else begin
                  w_next_out = MAX;
               end
            end else begin
               w_next_out = r_out - ONE_VAL;
            end
         end
      end else begin
         w_next_out = r_out;
      end
   end

   // A boundary event in the same cycle as a clear leaves the flag set.
   assign w_next_ovf = w_set_ovf | (r_ovf & ~clr_flags);
   assign w_next_unf = w_set_unf | (r_unf & ~clr_flags);

   // State register: synchronous reset discards any count in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= RST_V;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_out   <= w_next_out;
         r_carry <= w_next_carry;
         r_ovf   <= w_next_ovf;
         r_unf   <= w_next_unf;
      end
   end

   assign out   = r_out;
   assign carry = r_carry;
   assign ovf   = r_ovf;
   assign unf   = r_unf;
   assign tc    = (ctrl == DIR_UP) ? (r_out == MAX) : (r_out == ZERO);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Testbench for updown_counter_mod: directed plan plus random stimulus against
// an arithmetic reference model (MODULUS=10), and a MODULUS=16 boundary check.
module tb_updown_counter_mod;

   localparam int MOD_A = 10;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_en, a_ctrl, a_sat, a_load, a_clr;
   logic [3:0] a_lv;
   logic [3:0] a_out;
   logic       a_tc, a_carry, a_ovf, a_unf;

   logic       b_rst, b_en, b_ctrl, b_sat, b_load, b_clr;
   logic [3:0] b_lv;
   logic [3:0] b_out;
   logic       b_tc, b_carry, b_ovf, b_unf;

   int checks = 0;
   int errors = 0;

   int m_out   = 0;
   bit m_carry = 1'b0;
   bit m_ovf   = 1'b0;
   bit m_unf   = 1'b0;
   bit m_valid = 1'b0;

   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
      .clk(clk), .rst(a_rst), .en(a_en), .ctrl(a_ctrl), .sat_mode(a_sat),
      .load(a_load), .load_val(a_lv), .clr_flags(a_clr),
      .out(a_out), .tc(a_tc), .carry(a_carry), .ovf(a_ovf), .unf(a_unf)
   );

   updown_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(15)) dut_b (
      .clk(clk), .rst(b_rst), .en(b_en), .ctrl(b_ctrl), .sat_mode(b_sat),
      .load(b_load), .load_val(b_lv), .clr_flags(b_clr),
      .out(b_out), .tc(b_tc), .carry(b_carry), .ovf(b_ovf), .unf(b_unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock of dut_a: drive, check tc before the edge, advance model, check outputs.
   task automatic cycle(input logic rst_i, input logic en_i, input logic ctrl_i,
                        input logic sat_i, input logic load_i, input logic [3:0] lv_i,
                        input logic clr_i);
      int t;
      a_rst = rst_i; a_en = en_i; a_ctrl = ctrl_i; a_sat = sat_i;
      a_load = load_i; a_lv = lv_i; a_clr = clr_i;
      #1;
      if (m_valid) chk("tc", {31'd0, a_tc}, ctrl_i ? {31'd0, m_out == MOD_A - 1} : {31'd0, m_out == 0});
      @(posedge clk);
      if (rst_i) begin
         m_out = 0; m_carry = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b1;
      end else begin
         m_ovf = m_ovf && !clr_i;
         m_unf = m_unf && !clr_i;
         m_carry = 1'b0;
         if (load_i) begin
            m_out = (int'(lv_i) > MOD_A - 1) ? MOD_A - 1 : int'(lv_i);
         end else if (en_i) begin
            t = m_out + (ctrl_i ? 1 : -1);
            if (t < 0 || t >= MOD_A) begin
               m_carry = 1'b1;
               if (ctrl_i) m_ovf = 1'b1; else m_unf = 1'b1;
               if (!sat_i) m_out = (t + MOD_A) % MOD_A;
            end else begin
               m_out = t;
            end
         end
      end
      #1;
      chk("out",   {28'd0, a_out},   m_out);
      chk("carry", {31'd0, a_carry}, {31'd0, m_carry});
      chk("ovf",   {31'd0, a_ovf},   {31'd0, m_ovf});
      chk("unf",   {31'd0, a_unf},   {31'd0, m_unf});
   endtask

   initial begin
      b_rst = 1'b1; b_en = 1'b0; b_ctrl = 1'b1; b_sat = 1'b0;
      b_load = 1'b0; b_lv = 4'd0; b_clr = 1'b0;
      @(negedge clk);

      // Reset, then wrap-up count for 12 cycles.
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      chk("plan1_out", {28'd0, a_out}, 32'd2);
      chk("plan1_ovf", {31'd0, a_ovf}, 32'd1);

      // Saturated down-steps at 0.
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      chk("sat_carry", {31'd0, a_carry}, 32'd1);
      chk("sat_unf",   {31'd0, a_unf},   32'd1);

      // Load clamp, then in-range load.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 1'b0);
      chk("load_clamp", {28'd0, a_out}, 32'd9);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0);
      chk("load_4", {28'd0, a_out}, 32'd4);

      // Count to 7, reset mid-count, resume.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      chk("rst_out", {28'd0, a_out}, 32'd0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      chk("resume_out", {28'd0, a_out}, 32'd2);

      // Clear colliding with a wrap keeps ovf; clear alone drops it.
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("clr_collide_ovf", {31'd0, a_ovf}, 32'd1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("clr_alone_ovf", {31'd0, a_ovf}, 32'd0);

      // Random stimulus.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 9) == 0));
      end

      // Full-range modulus with RESET_VAL at the top.
      b_rst = 1'b1;
      @(posedge clk); #1;
      b_rst = 1'b0; b_ctrl = 1'b1; #1;
      chk("b_rst_out", {28'd0, b_out}, 32'd15);
      chk("b_rst_tc",  {31'd0, b_tc},  32'd1);
      b_en = 1'b1;
      @(posedge clk); #1;
      chk("b_up_out",   {28'd0, b_out},   32'd0);
      chk("b_up_carry", {31'd0, b_carry}, 32'd1);
      chk("b_up_ovf",   {31'd0, b_ovf},   32'd1);
      b_ctrl = 1'b0;
      @(posedge clk); #1;
      chk("b_dn_out",   {28'd0, b_out},   32'd15);
      chk("b_dn_carry", {31'd0, b_carry}, 32'd1);
      chk("b_dn_unf",   {31'd0, b_unf},   32'd1);
      b_en = 1'b0;
      @(posedge clk); #1;
      chk("b_idle_carry", {31'd0, b_carry}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
